// File: rtl/return_stack_if.sv
// return_stack_if: call/return port bundle between the fetch/PC logic and the return stack.
interface return_stack_if #(parameter int DEPTH = 8, parameter int AW = 12);
    logic                     push;
    logic                     pop;
    logic [AW-1:0]            push_data;
    logic [AW-1:0]            top;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;
    modport master (output push, pop, push_data, input top, count, empty, full, overflow, underflow);
    modport slave (input push, pop, push_data, output top, count, empty, full, overflow, underflow);
endinterface

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with zero-latency top and sticky error flags.
// Define RETURN_STACK_UNDERFLOW_DETECT_EN to latch pop-while-empty into underflow.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int AW = 12
) (
    input logic clk,
    input logic rst,
    return_stack_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    logic [AW-1:0] mem [DEPTH];
    logic [IW:0] cnt;
    logic ovf;
    logic is_empty, is_full, replace, do_push, do_pop;
    logic [IW-1:0] top_idx, wr_idx;
    always_comb begin
        is_empty = cnt == '0;
        is_full = cnt == (IW + 1)'(DEPTH);
        replace = bus.push && bus.pop && !is_empty;
        do_push = bus.push && !replace && !is_full;
        do_pop = bus.pop && !bus.push && !is_empty;
        top_idx = IW'(cnt - 1'b1);
        wr_idx = replace ? top_idx : IW'(cnt);
    end
    // entries are never cleared; only count decides what is valid
    always_ff @(posedge clk)
        if (!rst && (replace || do_push)) mem[wr_idx] <= bus.push_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= do_push ? cnt + 1'b1 : do_pop ? cnt - 1'b1 : cnt;
            ovf <= ovf | (bus.push && !bus.pop && is_full);
        end
    end
`ifdef RETURN_STACK_UNDERFLOW_DETECT_EN
    logic udf;
    always_ff @(posedge clk) begin
        if (rst) udf <= 1'b0;
        else udf <= udf | (bus.pop && !bus.push && is_empty);
    end
    assign bus.underflow = udf;
`else
    assign bus.underflow = 1'b0;
`endif
    assign bus.top = is_empty ? '0 : mem[top_idx];
    assign bus.count = cnt;
    assign bus.empty = is_empty;
    assign bus.full = is_full;
    assign bus.overflow = ovf;
endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of return-address entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 12, return-address width (matches 12-bit PC).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port push  input  1  store push_data as new top-of-stack (call).
REQ-006 SHALL have port pop  input  1  remove top-of-stack (return).
REQ-007 SHALL have port push_data  input  AW  return address to store (PC+1 from fetch).
REQ-008 SHALL have port top  output  AW  current top-of-stack, consumed by PC mux as return target.
REQ-009 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-010 SHALL have port empty  output  1  count==0.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-013 SHALL have port underflow  output  1  sticky: pop attempted while empty (see Configuration).

Function
REQ-014 SHALL drive top combinationally from entry[count-1]; top = 0 when empty; zero-latency so the PC mux captures the return target on the same edge that pop is applied.
REQ-015 SHALL on push only, not full: write push_data into entry[count], count+1; new value visible on top the following cycle.
REQ-016 SHALL on pop only, not empty: count-1; popped entry contents left unchanged (not cleared).
REQ-017 SHALL on push and pop together, not empty: overwrite entry[count-1] with push_data, count unchanged (tail-call/replace-top); no flag set, including when full.
REQ-018 SHALL on push and pop together, empty: behave as push only; underflow not set.
REQ-019 SHALL on push only while full: discard push_data, leave count and all entries unchanged, set overflow.
REQ-020 SHALL on pop only while empty: leave count at 0, top stays 0; underflow handling per REQ-026/027.
REQ-021 SHALL hold all state when push and pop are both low.
REQ-022 SHALL keep overflow and underflow set until rst; flags do not self-clear on later legal operations.
REQ-023 SHALL never wrap count: count stays within 0..DEPTH for all input sequences.

Reset
REQ-024 SHALL on rst high at a rising edge set count=0, overflow=0, underflow=0; empty=1, full=0, top=0 from the next cycle; entry contents need not be cleared.
REQ-025 SHALL give rst priority over push/pop in the same cycle; an operation coincident with rst is discarded.

Configuration
REQ-026 SHALL, when macro RETURN_STACK_UNDERFLOW_DETECT_EN is defined, set underflow on any pop-only cycle while empty.
REQ-027 SHALL, when RETURN_STACK_UNDERFLOW_DETECT_EN is undefined, tie underflow to constant 0 and omit its register; pop-while-empty is silently ignored, all other behaviour identical.

Verification
REQ-028 SHALL cover: rst; push 0x010, 0x020, 0x030 -> count=3, top=0x030; pop -> top=0x020 next cycle, count=2.
REQ-029 SHALL cover: DEPTH=8, push 0x100..0x107 -> full=1, overflow=0; push 0x1FF -> overflow=1, top=0x107, count=8; pop ×8 -> empty=1, top=0, overflow still 1.
REQ-030 SHALL cover: count=2 top=0x020, push=pop=1 with push_data=0xABC -> count=2, top=0xABC; pop -> top=0x010.
REQ-031 SHALL cover: empty, pop -> underflow=1 (macro defined) or 0 (macro undefined), count=0; empty, push=pop=1 with 0x055 -> count=1, top=0x055, underflow unchanged.
REQ-032 SHALL cover: count=5 with overflow=1, assert rst together with push=1 -> next cycle count=0, empty=1, overflow=0, top=0, push discarded.
